dm_access_ctrl: RTL and testbench
=================================

Name: dm_access_ctrl

Overview:
- Initiator side of the word-wide data-memory (DM) interface. The DM takes a byte address, store data and a write enable, reads combinationally and writes on the clock edge.
- Accepts CPU load/store requests (byte, halfword, word; signed or unsigned loads) through a valid/ready handshake and turns each one into DM word accesses.
- Sub-word stores are done as read-modify-write. Misaligned or out-of-range accesses are rejected.
- Sits between the pipeline MEM stage and the DM.

Parameters:
- DM_BYTES, 4096: DM size in bytes. Any address >= DM_BYTES is out of range.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  sign-extend loaded data (ignored for word size and for stores)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load result, extended; 0 for stores and errors
- resp_err  out  1  request rejected
- dm_addr  out  32  word-aligned DM address
- dm_store_data  out  32  DM store data
- dm_write_enable  out  1  DM write enable
- dm_load_data  in  32  DM combinational read data

Behaviour:
- Handshake and states:
  - States: IDLE, RD, WR, RESP.
  - req_ready = (state==IDLE) && !reset.
  - A request is accepted on a rising edge when req_valid && req_ready; all req_* fields are latched at that edge.
  - req_valid while busy is ignored; the requester must hold the request until ready.
- Acceptance decision, with acceptance edge = T:
  - Error if: size 11; half with addr[0]=1; word with addr[1:0]!=0; or addr >= DM_BYTES. Goes to RESP, resp_valid at T+1 with resp_err=1 and resp_rdata=0. No DM write occurs.
  - Load: RD at T+1, RESP at T+2.
  - Word store: WR at T+1, RESP at T+2. No read is performed.
  - Byte or half store: RD at T+1, WR at T+2, RESP at T+3.
- RD:
  - dm_addr = {addr[31:2],2'b00}.
  - dm_load_data is captured into an internal word buffer at the end of the cycle.
- Byte lanes (little-endian):
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Halfword occupies bits [16*addr[1]+15 : 16*addr[1]].
- Loads:
  - Extract the lane, then sign-extend (req_signed=1) or zero-extend to 32 bits. Word loads return the full word.
  - The result is held in resp_rdata during RESP.
- Stores:
  - The merged word is the buffer with only the addressed lane replaced by the low 8 or 16 bits of req_wdata. A word store uses req_wdata unchanged.
- WR:
  - dm_write_enable=1 for exactly one cycle.
  - dm_addr = word address; dm_store_data = merged word.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - A new request can be accepted on the edge ending the first IDLE cycle after RESP, so the minimum spacing is 3 cycles per load.
- dm_write_enable is 0 in every state other than WR.
- dm_addr and dm_store_data are registered and hold their last value outside RD/WR.
- Reset values: all outputs 0, state IDLE, internal buffers 0.
- Reset mid-operation:
  - The pending request is abandoned and no response is issued.
  - If reset is asserted during a RD cycle, no write follows.
  - If reset is asserted during the WR cycle, the DM still samples dm_write_enable=1 at that edge, so the write completes and is not rolled back.
- Addresses above DM_BYTES are never driven with dm_write_enable=1.

Test Plan:
- Word store: sw addr 0x10 data 0x8765_4321 accepted at T → T+1: dm_addr=0x10, dm_store_data=0x8765_4321, dm_write_enable=1 for one cycle; T+2: resp_valid=1, resp_err=0.
- Loads from word 0x8765_4321 at 0x10:
  - lb addr 0x13 signed → 0xFFFF_FF87
  - lbu 0x13 → 0x0000_0087
  - lh 0x12 signed → 0xFFFF_8765
  - lhu 0x10 → 0x0000_4321
  - lw 0x10 → 0x8765_4321
  - each response at T+2.
- Byte store: sb addr 0x11 data 0x0000_00AA → RD at T+1 (dm_write_enable=0), WR at T+2 with dm_store_data=0x8765_AA21, resp at T+3; a following lw 0x10 returns 0x8765_AA21.
- Errors: sh addr 0x13, lw addr 0x12, lw addr 0x1000 and req_size=11 each → resp_valid at T+1 with resp_err=1 and resp_rdata=0; dm_write_enable is never asserted.
- Reset mid-operation: reset=1 during the RD cycle of sb 0x11 → no dm_write_enable pulse, no resp_valid, all outputs 0 and req_ready=1 on the first cycle after reset deasserts; memory word unchanged.
- Back-to-back requests: req_valid held high with two lw requests → the second is accepted only on the edge after RESP, and exactly two resp_valid pulses are observed, 3 cycles apart.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: turns CPU load/store requests into word-wide
// DM reads and writes, doing read-modify-write for byte and halfword stores.
module dm_access_ctrl #(
   parameter int unsigned DM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_store_data,
   output logic        dm_write_enable,
   input  logic [31:0] dm_load_data
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [1:0]  lane_q, lane_d;
   logic [15:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic [31:0] dm_sdata_q, dm_sdata_d;
   logic        bad;

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] size, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lane)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = lane[1] ? w[31:16] : w[15:0];
      case (size)
         SZ_B:    r = {{24{sgn & b[7]}}, b};
         SZ_H:    r = {{16{sgn & h[15]}}, h};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                         input logic [1:0] size, input logic [15:0] d);
      logic [31:0] m;
      m = w;
      if (size == SZ_B) begin
         case (lane)
            2'd0:    m[7:0]   = d[7:0];
            2'd1:    m[15:8]  = d[7:0];
            2'd2:    m[23:16] = d[7:0];
            default: m[31:24] = d[7:0];
         endcase
      end else if (lane[1]) begin
         m[31:16] = d;
      end else begin
         m[15:0] = d;
      end
      return m;
   endfunction

   always_comb begin
      bad = (req_size == 2'b11)
         || (req_size == SZ_H && req_addr[0])
         || (req_size == SZ_W && req_addr[1:0] != 2'b00)
         || (req_addr >= DM_BYTES);
   end

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      signed_d   = signed_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      dm_addr_d  = dm_addr_q;
      dm_sdata_d = dm_sdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               size_d   = req_size;
               signed_d = req_signed;
               lane_d   = req_addr[1:0];
               wdata_d  = req_wdata[15:0];
               err_d    = bad;
               rdata_d  = '0;
               if (bad) begin
                  state_d = RESP;
               end else begin
                  dm_addr_d = {req_addr[31:2], 2'b00};
                  if (req_we && req_size == SZ_W) begin
                     dm_sdata_d = req_wdata;
                     state_d    = WR;
                  end else begin
                     state_d = RD;
                  end
               end
            end
         end
         RD: begin
            // The store-data register doubles as the read buffer: the word is
            // merged as it is captured, so WR can drive it straight out.
            if (we_q) begin
               dm_sdata_d = merge(dm_load_data, lane_q, size_q, wdata_q);
               state_d    = WR;
            end else begin
               rdata_d = load_ext(dm_load_data, lane_q, size_q, signed_q);
               state_d = RESP;
            end
         end
         WR:      state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         signed_q   <= 1'b0;
         lane_q     <= 2'b00;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         dm_addr_q  <= '0;
         dm_sdata_q <= '0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         lane_q     <= lane_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         dm_addr_q  <= dm_addr_d;
         dm_sdata_q <= dm_sdata_d;
      end
   end

   // Write enable follows the state, so a reset landing on WR still lets the write complete.
   assign req_ready       = (state_q == IDLE) && !reset;
   assign resp_valid      = (state_q == RESP);
   assign resp_err        = (state_q == RESP) && err_q;
   assign resp_rdata      = rdata_q;
   assign dm_addr         = dm_addr_q;
   assign dm_store_data   = dm_sdata_q;
   assign dm_write_enable = (state_q == WR);

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: DM model, cycle-scheduled reference model and
// per-cycle compare, with directed literal cases followed by random traffic.
module tb_dm_access_ctrl;
   localparam int DMB = 4096;
   localparam int NC  = 64;

   logic        clk = 1'b0, reset = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, dm_write_enable;
   logic [31:0] resp_rdata, dm_addr, dm_store_data, dm_load_data;

   always #5 clk = ~clk;

   dm_access_ctrl #(.DM_BYTES(DMB)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_addr(dm_addr),
      .dm_store_data(dm_store_data), .dm_write_enable(dm_write_enable),
      .dm_load_data(dm_load_data));

   // Data memory: combinational read, write on the edge
   logic [31:0] dm_mem [0:DMB/4-1] = '{default: 32'h0};
   assign dm_load_data = (dm_addr < DMB) ? dm_mem[dm_addr[11:2]] : 32'hDEAD_BEEF;
   always @(posedge clk)
      if (dm_write_enable && dm_addr < DMB) dm_mem[dm_addr[11:2]] <= dm_store_data;

   int n_vec = 0, n_bad = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
      end
   endtask

   // Reference model: expected events scheduled by absolute cycle number
   logic [31:0] ref_mem [0:DMB/4-1] = '{default: 32'h0};
   bit          e_resp [NC] = '{default: 1'b0};
   bit          e_err  [NC] = '{default: 1'b0};
   logic [31:0] e_rdata[NC] = '{default: 32'h0};
   bit          e_we   [NC] = '{default: 1'b0};
   logic [31:0] e_waddr[NC] = '{default: 32'h0};
   logic [31:0] e_wdata[NC] = '{default: 32'h0};
   bit          e_rd   [NC] = '{default: 1'b0};
   logic [31:0] e_raddr[NC] = '{default: 32'h0};
   int cyc = 0, next_free = 0;
   bit armed = 1'b0, rst_prev = 1'b0;

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sg);
      int sh;
      logic [31:0] v;
      sh = 8 * int'(a[1:0]);
      v  = w;
      if (sz == 2'd0) begin
         v = (w >> sh) & 32'hFF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> sh) & 32'hFFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input logic [31:0] d);
      int sh;
      logic [31:0] mask;
      sh   = 8 * int'(a[1:0]);
      mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((d << sh) & mask);
   endfunction

   function automatic bit m_bad(input logic [31:0] a, input logic [1:0] sz);
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
          || (a >= DMB);
   endfunction

   always @(posedge clk) begin
      int s, l;
      s = cyc % NC;
      if (armed && e_we[s]) ref_mem[e_waddr[s][11:2]] = e_wdata[s];
      if (reset) begin
         for (int k = 1; k <= 4; k++) begin
            e_resp[(cyc+k)%NC] = 0; e_we[(cyc+k)%NC] = 0; e_rd[(cyc+k)%NC] = 0;
         end
         next_free = cyc + 1;
         armed     = 1'b1;
      end else if (armed && req_valid && cyc >= next_free) begin
         if (m_bad(req_addr, req_size)) begin
            l = 1;
            e_err[(cyc+1)%NC] = 1; e_rdata[(cyc+1)%NC] = 0;
         end else if (!req_we) begin
            l = 2;
            e_rd[(cyc+1)%NC] = 1; e_raddr[(cyc+1)%NC] = req_addr & ~32'h3;
            e_err[(cyc+2)%NC] = 0;
            e_rdata[(cyc+2)%NC] = m_load(ref_mem[req_addr[11:2]], req_addr, req_size, req_signed);
         end else if (req_size == 2'd2) begin
            l = 2;
            e_we[(cyc+1)%NC] = 1; e_waddr[(cyc+1)%NC] = req_addr;
            e_wdata[(cyc+1)%NC] = req_wdata;
            e_err[(cyc+2)%NC] = 0; e_rdata[(cyc+2)%NC] = 0;
         end else begin
            l = 3;
            e_rd[(cyc+1)%NC] = 1; e_raddr[(cyc+1)%NC] = req_addr & ~32'h3;
            e_we[(cyc+2)%NC] = 1; e_waddr[(cyc+2)%NC] = req_addr & ~32'h3;
            e_wdata[(cyc+2)%NC] = m_merge(ref_mem[req_addr[11:2]], req_addr, req_size, req_wdata);
            e_err[(cyc+3)%NC] = 0; e_rdata[(cyc+3)%NC] = 0;
         end
         e_resp[(cyc+l)%NC] = 1;
         next_free = cyc + l + 1;
      end
      e_resp[s] = 0; e_we[s] = 0; e_rd[s] = 0;
      rst_prev = reset;
      cyc++;
   end

   // Single per-cycle compare against the model
   always @(negedge clk) begin
      int s;
      s = cyc % NC;
      if (armed) begin
         chk("req_ready", {31'b0, req_ready}, {31'b0, !reset && cyc >= next_free});
         chk("dm_write_enable", {31'b0, dm_write_enable}, {31'b0, e_we[s]});
         if (e_we[s]) begin
            chk("wr_dm_addr", dm_addr, e_waddr[s] & ~32'h3);
            chk("wr_dm_store_data", dm_store_data, e_wdata[s]);
         end
         if (e_rd[s]) chk("rd_dm_addr", dm_addr, e_raddr[s]);
         if (!reset) begin
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, e_resp[s]});
            if (e_resp[s]) begin
               chk("resp_err", {31'b0, resp_err}, {31'b0, e_err[s]});
               chk("resp_rdata", resp_rdata, e_rdata[s]);
            end
         end
         if (rst_prev) begin
            chk("rst_dm_addr", dm_addr, 32'h0);
            chk("rst_dm_store_data", dm_store_data, 32'h0);
            chk("rst_resp_rdata", resp_rdata, 32'h0);
            chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
         end
      end
   end

   task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = d;
   endtask

   task automatic wait_accept(input string nm);
      int t;
      t = 0;
      while (!req_ready && t < 20) begin
         @(negedge clk); #1; t++;
      end
      if (t == 20) chk({nm, "_accept_timeout"}, 32'h0, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic do_req(input string nm, input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
      int k;
      @(negedge clk); #1;
      drive(we, sz, sg, a, d);
      wait_accept(nm);
      k = 1;
      @(negedge clk);
      while (!resp_valid && k < 7) begin
         @(negedge clk); k++;
      end
      chk({nm, "_latency"}, k, exp_lat);
      chk({nm, "_rdata"}, resp_rdata, exp_rd);
      chk({nm, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
   endtask

   initial begin
      bit acc_last, rdy;
      int acc, np, c0, c1, r;
      repeat (3) @(posedge clk);
      @(negedge clk); #1 reset = 1'b0;

      do_req("sw",  1, 2'd2, 0, 32'h10, 32'h8765_4321, 32'h0, 0, 2);
      chk("sw_mem", dm_mem[4], 32'h8765_4321);
      do_req("lb",  0, 2'd0, 1, 32'h13, 0, 32'hFFFF_FF87, 0, 2);
      do_req("lbu", 0, 2'd0, 0, 32'h13, 0, 32'h0000_0087, 0, 2);
      do_req("lh",  0, 2'd1, 1, 32'h12, 0, 32'hFFFF_8765, 0, 2);
      do_req("lhu", 0, 2'd1, 0, 32'h10, 0, 32'h0000_4321, 0, 2);
      do_req("lw",  0, 2'd2, 0, 32'h10, 0, 32'h8765_4321, 0, 2);
      do_req("sb",  1, 2'd0, 0, 32'h11, 32'h0000_00AA, 32'h0, 0, 3);
      chk("sb_mem", dm_mem[4], 32'h8765_AA21);
      do_req("lw_after_sb", 0, 2'd2, 0, 32'h10, 0, 32'h8765_AA21, 0, 2);
      do_req("err_sh13",  1, 2'd1, 0, 32'h13, 32'hFFFF, 32'h0, 1, 1);
      do_req("err_lw12",  0, 2'd2, 0, 32'h12, 0, 32'h0, 1, 1);
      do_req("err_lw1000", 0, 2'd2, 0, 32'h1000, 0, 32'h0, 1, 1);
      do_req("err_size3", 0, 2'd3, 0, 32'h10, 0, 32'h0, 1, 1);
      chk("err_mem", dm_mem[4], 32'h8765_AA21);

      // Reset landing on the RD cycle of a byte store
      @(negedge clk); #1;
      drive(1, 2'd0, 0, 32'h11, 32'h55);
      wait_accept("rst_sb");
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_mem", dm_mem[4], 32'h8765_AA21);

      // Back-to-back loads with req_valid held
      #1 drive(0, 2'd2, 0, 32'h10, 0);
      acc = 0; np = 0; c0 = 0; c1 = 0;
      for (int k = 0; k < 14; k++) begin
         if (req_valid && req_ready) acc++;
         @(posedge clk); #1;
         if (acc == 2) req_valid = 1'b0;
         @(negedge clk);
         if (resp_valid) begin
            if (np == 0) c0 = cyc; else c1 = cyc;
            np++;
            chk("b2b_rdata", resp_rdata, 32'h8765_AA21);
         end
         #1;
      end
      chk("b2b_pulses", np, 2);
      chk("b2b_spacing", c1 - c0, 3);

      // Random traffic with occasional resets
      acc_last = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         if (acc_last || !req_valid) begin
            r = $urandom_range(0, 9);
            drive($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                  (r < 8) ? $urandom_range(0, 63) : (r == 8) ? 32'hFF8 + $urandom_range(0, 15)
                                                            : $urandom(),
                  $urandom());
            req_valid = ($urandom_range(0, 3) != 0);
         end
         reset = ($urandom_range(0, 49) == 0);
         #1 rdy = req_ready;
         acc_last = req_valid && rdy;
      end
      @(negedge clk); #1 req_valid = 1'b0; reset = 1'b0;
      repeat (6) @(negedge clk);
      for (int w = 0; w < DMB/4; w++)
         if (dm_mem[w] !== ref_mem[w]) chk($sformatf("mem_word_%0d", w), dm_mem[w], ref_mem[w]);
      chk("mem_final_w4", dm_mem[4], ref_mem[4]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
